fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the 16-bit RISC core.
- Owns the program counter and drives the address input of the combinational instruction memory (16-bit address, 24-bit word).
- Latches each fetched word into an instruction register and hands it to the decode/execute datapath over a valid/ready handshake.
- Also handles start, branch redirect and HALT.

---
 rtl/fetch_sequencer.sv | 83 ++++++++
 tb/tb_fetch_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, latches memory words into the
// instruction register and offers them to the datapath over valid/ready.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] imem_addr,
  input  logic [23:0] imem_data,
  output logic [23:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic [15:0] pc,
  output logic        halted,
  output logic [15:0] issue_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t state;
  logic   fire;

  // A redirect squashes the handshake even when the datapath is ready.
  assign fire      = ir_valid & ir_ready & ~redirect;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      issue_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (redirect) begin
            pc <= redirect_addr;
          end else if (imem_data[23:20] == HALT_OPCODE) begin
            ir     <= imem_data;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            ir       <= imem_data;
            pc       <= pc + 16'd1;
            ir_valid <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (redirect) begin
            ir_valid <= 1'b0;
            pc       <= redirect_addr;
            state    <= S_FETCH;
          end else if (fire) begin
            ir_valid    <= 1'b0;
            issue_count <= issue_count + 16'd1;
            state       <= S_FETCH;
          end
        end
        S_HALT: begin
          ir_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected issued words are queued when
// a program is loaded and popped as handshakes complete.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_w = 1'b0;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;

  logic [15:0] imem_addr, pc, issue_count;
  logic [23:0] imem_data, ir;
  logic        ir_valid, halted;

  logic [15:0] w_imem_addr, w_pc, w_issue_count;
  logic [23:0] w_imem_data, w_ir;
  logic        w_ir_valid, w_halted;

  logic [23:0] mem0 [0:65535];
  logic [23:0] mem1 [0:65535];
  logic [23:0] exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  assign imem_data   = mem0[imem_addr];
  assign w_imem_data = mem1[w_imem_addr];

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .pc(pc), .halted(halted), .issue_count(issue_count)
  );

  fetch_sequencer #(.RESET_PC(16'hFFFF), .HALT_OPCODE(4'hF)) u_wrap (
    .clk(clk), .rst(rst), .start(start_w),
    .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .ir(w_ir), .ir_valid(w_ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .pc(w_pc), .halted(w_halted), .issue_count(w_issue_count)
  );

  task automatic apply_reset();
    start = 1'b0; start_w = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_prog();
    for (int unsigned i = 0; i < 65536; i++) begin
      mem0[i] = 24'hf00000;
      mem1[i] = 24'hf00000;
    end
    mem0[0] = 24'hc10005;
    mem0[1] = 24'hd20004;
    mem0[2] = 24'h131200;
    mem0[3] = 24'hf00000;
    mem1[16'hFFFF] = 24'h131200;
    mem1[0]        = 24'hf00000;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", pc); end
    vectors++; if (imem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_imem_addr: got %h want 0000", imem_addr); end
    vectors++; if (ir !== 24'h000000) begin miscompares++; $display("FAIL reset_ir: got %h want 000000", ir); end
    vectors++; if (ir_valid !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got v=%b h=%b want 0 0", ir_valid, halted); end
    vectors++; if (issue_count !== 16'h0000) begin miscompares++; $display("FAIL reset_count: got %h want 0000", issue_count); end
  endtask

  task automatic test_basic_program();
    int first = -1;
    int last = 0;
    logic [23:0] e;
    apply_reset();
    exp_q = {24'hc10005, 24'hd20004, 24'h131200};
    ir_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40 && !halted; c++) begin
      if (ir_valid) begin
        if (first < 0) begin
          first = c;
          vectors++; if (c != 2) begin miscompares++; $display("FAIL basic_latency: got %0d want 2", c); end
        end else begin
          vectors++; if (c - last != 2) begin miscompares++; $display("FAIL basic_spacing: got %0d want 2", c - last); end
        end
        last = c;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        vectors++; if (ir !== e) begin miscompares++; $display("FAIL basic_ir: got %h want %h", ir, e); end
      end
      @(negedge clk);
    end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL basic_halt_timeout: got halted=%b want 1", halted); end
    vectors++; if (pc !== 16'h0003) begin miscompares++; $display("FAIL basic_pc: got %h want 0003", pc); end
    vectors++; if (issue_count !== 16'd3) begin miscompares++; $display("FAIL basic_count: got %0d want 3", issue_count); end
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid: got %b want 0", ir_valid); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL basic_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_halt_ignore();
    for (int c = 0; c < 6; c++) begin
      start = c[0];
      redirect = ~c[0];
      redirect_addr = 16'h1234;
      ir_ready = c[1];
      @(negedge clk);
      vectors++; if (pc !== 16'h0003 || halted !== 1'b1 || ir_valid !== 1'b0)
        begin miscompares++; $display("FAIL halt_ignore: got pc=%h h=%b v=%b want 0003 1 0", pc, halted, ir_valid); end
    end
    start = 1'b0; redirect = 1'b0;
    vectors++; if (issue_count !== 16'd3) begin miscompares++; $display("FAIL halt_count: got %0d want 3", issue_count); end
  endtask

  task automatic test_backpressure();
    int c;
    apply_reset();
    ir_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 20 && !ir_valid; c++) @(negedge clk);
    vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL bp_wait_valid: got %b want 1", ir_valid); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++; if (ir !== 24'hc10005 || ir_valid !== 1'b1 || pc !== 16'h0001)
        begin miscompares++; $display("FAIL bp_hold: got ir=%h v=%b pc=%h want c10005 1 0001", ir, ir_valid, pc); end
    end
    vectors++; if (issue_count !== 16'd0) begin miscompares++; $display("FAIL bp_count_held: got %0d want 0", issue_count); end
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    vectors++; if (issue_count !== 16'd1 || ir_valid !== 1'b0)
      begin miscompares++; $display("FAIL bp_release: got cnt=%0d v=%b want 1 0", issue_count, ir_valid); end
    repeat (3) @(negedge clk);
    vectors++; if (issue_count !== 16'd1) begin miscompares++; $display("FAIL bp_single_fire: got %0d want 1", issue_count); end
  endtask

  task automatic test_redirect();
    logic        done = 1'b0;
    logic        pending = 1'b0;
    logic [15:0] cnt_before = '0;
    logic [23:0] e;
    apply_reset();
    exp_q = {24'hc10005, 24'hc10005, 24'hd20004, 24'h131200};
    ir_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60 && !halted; c++) begin
      if (pending) begin
        pending = 1'b0;
        redirect = 1'b0;
        vectors++; if (issue_count !== cnt_before || ir_valid !== 1'b0 || pc !== 16'h0000)
          begin miscompares++; $display("FAIL redir_effect: got cnt=%0d v=%b pc=%h want %0d 0 0000", issue_count, ir_valid, pc, cnt_before); end
      end else if (ir_valid) begin
        if (!done && ir === 24'hd20004) begin
          done = 1'b1;
          pending = 1'b1;
          cnt_before = issue_count;
          redirect = 1'b1;
          redirect_addr = 16'h0000;
        end else begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
          vectors++; if (ir !== e) begin miscompares++; $display("FAIL redir_ir: got %h want %h", ir, e); end
        end
      end
      @(negedge clk);
    end
    redirect = 1'b0;
    vectors++; if (halted !== 1'b1 || !done) begin miscompares++; $display("FAIL redir_timeout: got halted=%b want 1", halted); end
    vectors++; if (issue_count !== 16'd4) begin miscompares++; $display("FAIL redir_count: got %0d want 4", issue_count); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL redir_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [23:0] e;
    apply_reset();
    vectors++; if (w_pc !== 16'hFFFF || w_imem_addr !== 16'hFFFF)
      begin miscompares++; $display("FAIL wrap_reset_pc: got %h/%h want ffff", w_pc, w_imem_addr); end
    exp_q = {24'h131200};
    ir_ready = 1'b1;
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    for (int c = 0; c < 20 && !w_halted; c++) begin
      if (w_ir_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        vectors++; if (w_ir !== e) begin miscompares++; $display("FAIL wrap_ir: got %h want %h", w_ir, e); end
        vectors++; if (w_pc !== 16'h0000) begin miscompares++; $display("FAIL wrap_pc: got %h want 0000", w_pc); end
      end
      @(negedge clk);
    end
    vectors++; if (w_halted !== 1'b1 || w_pc !== 16'h0000 || w_issue_count !== 16'd1)
      begin miscompares++; $display("FAIL wrap_end: got h=%b pc=%h cnt=%0d want 1 0000 1", w_halted, w_pc, w_issue_count); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    ir_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !ir_valid; c++) @(negedge clk);
    @(negedge clk);
    vectors++; if (ir_valid !== 1'b1 || pc !== 16'h0001) begin miscompares++; $display("FAIL arst_setup: got v=%b pc=%h want 1 0001", ir_valid, pc); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (ir_valid !== 1'b0 || pc !== 16'h0000 || ir !== 24'h000000 || halted !== 1'b0 || issue_count !== 16'h0000)
      begin miscompares++; $display("FAIL arst_immediate: got v=%b pc=%h ir=%h h=%b cnt=%0d want 0 0000 000000 0 0", ir_valid, pc, ir, halted, issue_count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (ir_valid !== 1'b0 || pc !== 16'h0000) begin miscompares++; $display("FAIL arst_idle: got v=%b pc=%h want 0 0000", ir_valid, pc); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    vectors++; if (ir_valid !== 1'b1 || ir !== 24'hc10005 || pc !== 16'h0001)
      begin miscompares++; $display("FAIL arst_restart: got v=%b ir=%h pc=%h want 1 c10005 0001", ir_valid, ir, pc); end
  endtask

  initial begin
    load_prog();
    test_reset();
    test_basic_program();
    test_halt_ignore();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
